vid_out: RTL

Downstream consumer of the character-generator pixel stream at the video output. Buffers the `vsync/req/eol/eof/pixel` stream in a small FIFO and drives a free-running VGA/DVI-style raster (`hsync`, `vsync`, `de`, 24-bit RGB) from programmable timing. Checks the stream's line and frame markers against the raster and recovers automatically on underflow, overflow or misalignment.

---
 rtl/vid_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/vid_out.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/vid_pkg.sv
// Shared timing defaults, state encoding and colour constants for the video output path.
package vid_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam logic [23:0] BLACK   = 24'h000000;
  localparam logic [23:0] MAGENTA = 24'hff00ff;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } vid_out_state_t;

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data (valid the cycle after pop), level output and one-cycle flush.
// Write-to-read latency 1; a push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == LW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_level = r_count;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign w_push  = i_push && (!o_full || w_pop) && !i_flush;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      o_rdata  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        o_rdata  <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/vid_out.sv
// Raster generator fed from the buffered pixel stream; checks eol/eof markers against the raster.
// Raster position reaches vga_* two clocks later; the input has no backpressure, excess pushes are dropped.
module vid_out
  import vid_pkg::*;
#(
  parameter int          H_ACTIVE        = DEF_H_ACTIVE,
  parameter int          H_FP            = DEF_H_FP,
  parameter int          H_SYNC          = DEF_H_SYNC,
  parameter int          H_BP            = DEF_H_BP,
  parameter int          V_ACTIVE        = DEF_V_ACTIVE,
  parameter int          V_FP            = DEF_V_FP,
  parameter int          V_SYNC          = DEF_V_SYNC,
  parameter int          V_BP            = DEF_V_BP,
  parameter int          FIFO_DEPTH      = 16,
  parameter int          PREFILL         = 8,
  parameter logic [23:0] UNDERFLOW_COLOR = MAGENTA
) (
  input  logic        vo_clk,
  input  logic        vo_reset,
  input  logic        in_vsync,
  input  logic        in_req,
  input  logic        in_eol,
  input  logic        in_eof,
  input  logic [23:0] in_pixel,
  input  logic        status_clr,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic [23:0] vga_pixel,
  output logic        underflow,
  output logic        overflow,
  output logic        sync_err
);
  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC0 = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC1 = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC0 = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC1 = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [LW-1:0] PRE_LVL = LW'(PREFILL);

  logic [HW-1:0]  r_h_cnt;
  logic [VW-1:0]  r_v_cnt;
  vid_out_state_t r_state;
  logic           r_bad;

  logic           r_s1_de, r_s1_hs_n, r_s1_vs_n, r_s1_show, r_s1_uf;
  logic           r_s1_popped, r_s1_last_col, r_s1_last_px;
  logic           r_underflow, r_overflow, r_sync_err;

  logic           w_active, w_hs_n, w_vs_n, w_boundary, w_last_col, w_last_px;
  logic           w_push, w_pop, w_flush, w_full, w_empty;
  logic [LW-1:0]  w_level;
  logic [25:0]    w_rdata;
  logic           w_uf_ev, w_of_ev, w_sync_ev, w_err_ev;

  assign w_active   = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_n     = !((r_h_cnt >= H_SYNC0) && (r_h_cnt < H_SYNC1));
  assign w_vs_n     = !((r_v_cnt >= V_SYNC0) && (r_v_cnt < V_SYNC1));
  assign w_boundary = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);
  assign w_last_col = w_active && (r_h_cnt == H_ACT - HW'(1));
  assign w_last_px  = w_last_col && (r_v_cnt == V_ACT - VW'(1));

  assign w_push  = in_req && (r_state != IDLE);
  assign w_pop   = w_active && (r_state == RUN);
  assign w_flush = in_vsync && (r_state != RUN);

  // Markers are checked one cycle late, against the position the entry was popped at.
  assign w_uf_ev   = w_pop && w_empty;
  assign w_of_ev   = w_push && w_full && !w_pop && !w_flush;
  assign w_sync_ev = r_s1_popped &&
                     ((w_rdata[25] != r_s1_last_col) || (w_rdata[24] != r_s1_last_px));
  assign w_err_ev  = w_uf_ev || w_of_ev || w_sync_ev;

  sync_fifo #(
    .WIDTH (26),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (vo_clk),
    .i_rst   (vo_reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_wdata ({in_eol, in_eof, in_pixel}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge vo_clk or posedge vo_reset) begin
    if (vo_reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  always_ff @(posedge vo_clk or posedge vo_reset) begin
    if (vo_reset) begin
      r_state <= IDLE;
      r_bad   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_vsync) r_state <= FILL;
        FILL: begin
          if (w_of_ev) begin
            r_state <= IDLE;
          end else if (!in_vsync && w_boundary && (w_level >= PRE_LVL)) begin
            r_state <= RUN;
            r_bad   <= 1'b0;
          end
        end
        RUN: begin
          if (w_boundary) begin
            if (r_bad || w_err_ev) r_state <= IDLE;
            r_bad <= 1'b0;
          end else if (w_err_ev) begin
            r_bad <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge vo_clk or posedge vo_reset) begin
    if (vo_reset) begin
      r_s1_de       <= 1'b0;
      r_s1_hs_n     <= 1'b1;
      r_s1_vs_n     <= 1'b1;
      r_s1_show     <= 1'b0;
      r_s1_uf       <= 1'b0;
      r_s1_popped   <= 1'b0;
      r_s1_last_col <= 1'b0;
      r_s1_last_px  <= 1'b0;
      vga_de        <= 1'b0;
      vga_hsync     <= 1'b1;
      vga_vsync     <= 1'b1;
      vga_pixel     <= '0;
    end else begin
      r_s1_de       <= w_active;
      r_s1_hs_n     <= w_hs_n;
      r_s1_vs_n     <= w_vs_n;
      r_s1_show     <= w_pop;
      r_s1_uf       <= w_uf_ev;
      r_s1_popped   <= w_pop && !w_empty;
      r_s1_last_col <= w_last_col;
      r_s1_last_px  <= w_last_px;
      vga_de        <= r_s1_de;
      vga_hsync     <= r_s1_hs_n;
      vga_vsync     <= r_s1_vs_n;
      if (!r_s1_de)       vga_pixel <= BLACK;
      else if (r_s1_uf)   vga_pixel <= UNDERFLOW_COLOR;
      else if (r_s1_show) vga_pixel <= w_rdata[23:0];
      else                vga_pixel <= BLACK;
    end
  end

  always_ff @(posedge vo_clk or posedge vo_reset) begin
    if (vo_reset) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      if (w_uf_ev)         r_underflow <= 1'b1;
      else if (status_clr) r_underflow <= 1'b0;
      if (w_of_ev)         r_overflow  <= 1'b1;
      else if (status_clr) r_overflow  <= 1'b0;
      if (w_sync_ev)       r_sync_err  <= 1'b1;
      else if (status_clr) r_sync_err  <= 1'b0;
    end
  end

  assign underflow = r_underflow;
  assign overflow  = r_overflow;
  assign sync_err  = r_sync_err;
endmodule
